// File: rtl/mlops_pkg.sv
// mlops_pkg: lane type and width helpers shared by the packer and the reduction stage.
package mlops_pkg;
  localparam int NBITS = 12;
  typedef logic signed [2*NBITS-1:0] lane_t;
  function automatic int clog2p1(input int n);
    return $clog2(n + 1);
  endfunction
endpackage

// File: rtl/vec_packer.sv
// vec_packer: packs a scalar word stream into zero-padded Elements-lane vectors for the adder tree.
module vec_packer
  import mlops_pkg::*;
#(
  parameter int Elements = 12,
  parameter int NBits    = 12
) (
  input  logic                                clk_in,
  input  logic                                rst_n_in,
  input  logic [2*NBits-1:0]                  s_data,
  input  logic                                s_valid,
  input  logic                                s_last,
  output logic                                s_ready,
  output logic [Elements-1:0][2*NBits-1:0]    m_data,
  output logic [clog2p1(Elements)-1:0]        m_count,
  output logic                                m_last,
  output logic                                m_valid,
  input  logic                                m_ready
);
  localparam int W  = 2*NBits;
  localparam int CW = clog2p1(Elements);
  typedef logic [Elements-1:0][W-1:0] vec_t;
  vec_t fill_q, fill_d, m_data_q, m_data_d, lanes;
  logic [CW-1:0] idx_q, idx_d, m_count_q, m_count_d, pend_cnt_q, pend_cnt_d;
  logic pend_q, pend_d, pend_last_q, pend_last_d, m_last_q, m_last_d, m_valid_q, m_valid_d;
  logic rdy_q, in_beat, out_free, complete;
  assign s_ready = rdy_q && !pend_q;
  assign m_data  = m_data_q;
  assign m_count = m_count_q;
  assign m_last  = m_last_q;
  assign m_valid = m_valid_q;
  always_comb begin
    in_beat  = s_valid && s_ready;
    out_free = !m_valid_q || m_ready;
    complete = in_beat && (s_last || idx_q == CW'(Elements-1));
    lanes    = fill_q;
    for (int i = 0; i < Elements; i++) if (idx_q == CW'(i)) lanes[i] = s_data;
    fill_d      = fill_q;
    idx_d       = idx_q;
    pend_d      = pend_q;
    pend_cnt_d  = pend_cnt_q;
    pend_last_d = pend_last_q;
    m_data_d    = m_data_q;
    m_count_d   = m_count_q;
    m_last_d    = m_last_q;
    m_valid_d   = m_valid_q && !m_ready;
    // s_ready is low while pending, so a drain and a new beat never coincide
    if (pend_q && out_free) begin
      m_data_d  = fill_q;
      m_count_d = pend_cnt_q;
      m_last_d  = pend_last_q;
      m_valid_d = 1'b1;
      fill_d    = '0;
      pend_d    = 1'b0;
    end else if (complete && out_free) begin
      m_data_d  = lanes;
      m_count_d = idx_q + CW'(1);
      m_last_d  = s_last;
      m_valid_d = 1'b1;
      fill_d    = '0;
      idx_d     = '0;
    end else if (complete) begin
      fill_d      = lanes;
      pend_d      = 1'b1;
      pend_cnt_d  = idx_q + CW'(1);
      pend_last_d = s_last;
      idx_d       = '0;
    end else if (in_beat) begin
      fill_d = lanes;
      idx_d  = idx_q + CW'(1);
    end
  end
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      rdy_q       <= 1'b0;
      fill_q      <= '0;
      idx_q       <= '0;
      pend_q      <= 1'b0;
      pend_cnt_q  <= '0;
      pend_last_q <= 1'b0;
      m_data_q    <= '0;
      m_count_q   <= '0;
      m_last_q    <= 1'b0;
      m_valid_q   <= 1'b0;
    end else begin
      rdy_q       <= 1'b1;
      fill_q      <= fill_d;
      idx_q       <= idx_d;
      pend_q      <= pend_d;
      pend_cnt_q  <= pend_cnt_d;
      pend_last_q <= pend_last_d;
      m_data_q    <= m_data_d;
      m_count_q   <= m_count_d;
      m_last_q    <= m_last_d;
      m_valid_q   <= m_valid_d;
    end
  end
endmodule
